sd_crc_7: RTL and testbench



---
 rtl/sd_crc_7.sv | 40 ++++
 tb/tb_sd_crc_7.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sd_crc_7.sv
// Serial CRC-7 (x^7 + x^3 + 1, zero seed) for the SD command line.
// One bit per SD clock, MSB first; the register drives CRC directly.
module sd_crc_7 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BITVAL,
    input  logic       ENABLE,
    output logic [6:0] CRC
);

    logic [6:0] crc_r;
    logic [6:0] crc_next_s;

    // Single LFSR step: feedback enters bit 0 and is folded into bit 3
    function automatic logic [6:0] crc7_step(input logic [6:0] cur, input logic din);
        logic inv;
        inv = din ^ cur[6];
        return {cur[5:3], cur[2] ^ inv, cur[1:0], inv};
    endfunction

    // Next-state selection; BITVAL is only looked at when ENABLE is high
    always_comb begin
        crc_next_s = crc_r;
        if (RST) begin
            crc_next_s = 7'h00;
        end else if (ENABLE) begin
            crc_next_s = crc7_step(crc_r, BITVAL);
        end else begin
            crc_next_s = crc_r;
        end
    end

    // CRC state register
    always_ff @(posedge CLK) begin
        crc_r <= crc_next_s;
    end

    assign CRC = crc_r;

endmodule

// File: tb/tb_sd_crc_7.sv
// Directed self-checking bench for sd_crc_7 using known SD command CRCs.
module tb_sd_crc_7;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BITVAL = 1'b0;
    logic       ENABLE = 1'b0;
    logic [6:0] CRC;

    int errors = 0;
    int checks = 0;

    sd_crc_7 dut (
        .CLK    (CLK),
        .RST    (RST),
        .BITVAL (BITVAL),
        .ENABLE (ENABLE),
        .CRC    (CRC)
    );

    always #5 CLK = ~CLK;

    // Apply inputs on the falling edge, return 1 time unit after the rising edge
    task automatic drive(input logic rst, input logic en, input logic b);
        @(negedge CLK);
        RST    = rst;
        ENABLE = en;
        BITVAL = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic shift_word(input logic [39:0] w);
        for (int i = 39; i >= 0; i--) drive(1'b0, 1'b1, w[i]);
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (CRC !== 7'h00) begin
            errors++;
            $display("FAIL reset_value actual=%h expected=%h", CRC, 7'h00);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, i[0]);
            checks++;
            if (CRC !== 7'h00) begin
                errors++;
                $display("FAIL reset_hold[%0d] actual=%h expected=%h", i, CRC, 7'h00);
            end
        end
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (CRC !== 7'h00) begin
            errors++;
            $display("FAIL reset_over_enable actual=%h expected=%h", CRC, 7'h00);
        end
    endtask

    task automatic test_single_step;
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (CRC !== 7'h09) begin
            errors++;
            $display("FAIL step_one actual=%h expected=%h", CRC, 7'h09);
        end
        drive(1'b0, 1'b1, 1'b0);
        checks++;
        if (CRC !== 7'h12) begin
            errors++;
            $display("FAIL step_zero actual=%h expected=%h", CRC, 7'h12);
        end
    endtask

    task automatic test_cmd0_hold;
        drive(1'b1, 1'b0, 1'b0);
        shift_word(40'h40_0000_0000);
        checks++;
        if (CRC !== 7'h4A) begin
            errors++;
            $display("FAIL cmd0 actual=%h expected=%h", CRC, 7'h4A);
        end
        // Remainder must hold while the host shifts it out with ENABLE low
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, ~i[0]);
            checks++;
            if (CRC !== 7'h4A) begin
                errors++;
                $display("FAIL cmd0_hold[%0d] actual=%h expected=%h", i, CRC, 7'h4A);
            end
        end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b0, 1'b0);
        shift_word(40'h48_0000_01AA);
        checks++;
        if (CRC !== 7'h43) begin
            errors++;
            $display("FAIL cmd8 actual=%h expected=%h", CRC, 7'h43);
        end
        drive(1'b1, 1'b0, 1'b0);
        shift_word(40'h51_0000_0000);
        checks++;
        if (CRC !== 7'h2A) begin
            errors++;
            $display("FAIL cmd17 actual=%h expected=%h", CRC, 7'h2A);
        end
    endtask

    task automatic test_self_check;
        logic [6:0] tail;
        tail = 7'h4A;
        drive(1'b1, 1'b0, 1'b0);
        shift_word(40'h40_0000_0000);
        for (int i = 6; i >= 0; i--) drive(1'b0, 1'b1, tail[i]);
        checks++;
        if (CRC !== 7'h00) begin
            errors++;
            $display("FAIL self_check actual=%h expected=%h", CRC, 7'h00);
        end
    endtask

    task automatic test_gaps;
        logic [39:0] w;
        int          gap;
        w = 40'h40_0000_0000;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 39; i >= 0; i--) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            drive(1'b0, 1'b1, w[i]);
        end
        checks++;
        if (CRC !== 7'h4A) begin
            errors++;
            $display("FAIL cmd0_gaps actual=%h expected=%h", CRC, 7'h4A);
        end
    endtask

    task automatic test_mid_reset;
        logic [39:0] w;
        w = 40'h48_0000_01AA;
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 39; i >= 20; i--) drive(1'b0, 1'b1, w[i]);
        drive(1'b1, 1'b1, 1'b1);
        checks++;
        if (CRC !== 7'h00) begin
            errors++;
            $display("FAIL mid_reset_clear actual=%h expected=%h", CRC, 7'h00);
        end
        shift_word(w);
        checks++;
        if (CRC !== 7'h43) begin
            errors++;
            $display("FAIL mid_reset_cmd8 actual=%h expected=%h", CRC, 7'h43);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_cmd0_hold();
        test_back_to_back();
        test_self_check();
        test_gaps();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
